// File: rtl/delay_line_arbiter_if.sv
// Requester/consumer bundle for delay_line_arbiter: request, data and stall inputs,
// together with the grant and pipeline-tail outputs.
interface delay_line_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
    logic                          hold;
    logic [NUM_REQ-1:0]            grant;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_WIDTH-1:0]           out_id;

    modport master (
        output req, data_in, hold,
        input  grant, out_valid, out_data, out_id
    );

    modport slave (
        input  req, data_in, hold,
        output grant, out_valid, out_data, out_id
    );
endinterface

// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter feeding one shared DEPTH-stage delay pipeline (word + id + valid).
// Latency: a grant in cycle t reaches the tail DEPTH non-held edges later; grant is combinational.
// Backpressure: hold freezes stages and pointer and blocks grants; the tail has no backpressure.
// Optional DELAY_LINE_ARB_OCC_EN adds a registered occupancy count output.
module delay_line_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 3,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic rst,
`ifdef DELAY_LINE_ARB_OCC_EN
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
`endif
    delay_line_arbiter_if.slave bus
);

    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic                  gnt_any;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_nxt;

    logic                  stg_vld [DEPTH];
    logic [ID_WIDTH-1:0]   stg_id  [DEPTH];
    logic [DATA_WIDTH-1:0] stg_dat [DEPTH];
    logic                  tail_vld;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from lowest to highest priority so the highest-priority requester is the last writer.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (!rst && !bus.hold) begin
            for (int off = NUM_REQ-1; off >= 0; off--) begin
                idx = int'(ptr) + off;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (bus.req[ID_WIDTH'(idx)]) begin
                    gnt_any = 1'b1;
                    gnt_id  = ID_WIDTH'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.grant = '0;
        if (gnt_any) begin
            bus.grant[gnt_id] = 1'b1;
        end
    end

    // Explicit wrap keeps non-power-of-two NUM_REQ from visiting unused ids.
    assign ptr_nxt = (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + ID_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                stg_vld[s] <= 1'b0;
                stg_id[s]  <= '0;
                stg_dat[s] <= '0;
            end
        end else if (!bus.hold) begin
            if (gnt_any) begin
                ptr <= ptr_nxt;
            end
            stg_vld[0] <= gnt_any;
            stg_id[0]  <= gnt_id;
            stg_dat[0] <= words[gnt_id];
            for (int s = 1; s < DEPTH; s++) begin
                stg_vld[s] <= stg_vld[s-1];
                stg_id[s]  <= stg_id[s-1];
                stg_dat[s] <= stg_dat[s-1];
            end
        end
    end

    assign tail_vld      = stg_vld[DEPTH-1];
    assign bus.out_valid = tail_vld;
    assign bus.out_id    = stg_id[DEPTH-1];
    assign bus.out_data  = stg_dat[DEPTH-1];

`ifdef DELAY_LINE_ARB_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else if (!bus.hold) begin
            if (gnt_any && !tail_vld) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (!gnt_any && tail_vld) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Bench for delay_line_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_delay_line_arbiter;
    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int DEP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_line_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) ifc ();
    delay_line_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(3))  ifc2 ();

`ifdef DELAY_LINE_ARB_OCC_EN
    logic [1:0] occ;
    logic [1:0] occ2;
`endif

    delay_line_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DELAY_LINE_ARB_OCC_EN
        .occupancy (occ),
`endif
        .bus       (ifc)
    );

    delay_line_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3), .DEPTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
`ifdef DELAY_LINE_ARB_OCC_EN
        .occupancy (occ2),
`endif
        .bus       (ifc2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(int i, int v);
        ifc.data_in[i*DW +: DW] = DW'(v);
    endtask

    task automatic set_word2(int i, int v);
        ifc2.data_in[i*DW +: DW] = DW'(v);
    endtask

    // Reference model: the pipeline is a FIFO of what entered on each non-held edge;
    // the front element is what the tail must show.
    typedef struct {
        bit v;
        int id;
        int d;
    } ent_t;

    ent_t line[$];
    int   m_ptr    = 0;
    bit   model_ok = 1'b0;

    always @(negedge clk) begin
        int   g;
        int   cnt;
        ent_t e;
        g = -1;
        if (!rst && !ifc.hold) begin
            for (int o = 0; o < NR; o++) begin
                if (g < 0 && ifc.req[(m_ptr + o) % NR]) g = (m_ptr + o) % NR;
            end
        end
        check("m_grant", ifc.grant, (g < 0) ? 0 : (1 << g));
        if (model_ok) begin
            check("m_out_valid", ifc.out_valid, line[0].v);
            if (line[0].v) begin
                check("m_out_id", ifc.out_id, line[0].id);
                check("m_out_data", ifc.out_data, line[0].d);
            end
`ifdef DELAY_LINE_ARB_OCC_EN
            cnt = 0;
            foreach (line[i]) if (line[i].v) cnt++;
            check("m_occupancy", occ, cnt);
`endif
        end
        if (rst) begin
            line.delete();
            for (int i = 0; i < DEP; i++) begin
                e.v = 1'b0; e.id = 0; e.d = 0;
                line.push_back(e);
            end
            m_ptr    = 0;
            model_ok = 1'b1;
        end else if (!ifc.hold && model_ok) begin
            e.v  = (g >= 0);
            e.id = (g < 0) ? 0 : g;
            e.d  = (g < 0) ? 0 : int'(ifc.data_in[e.id*DW +: DW]);
            void'(line.pop_front());
            line.push_back(e);
            if (g >= 0) m_ptr = (g + 1) % NR;
        end
    end

    initial begin
        logic [NR-1:0] g;
        ifc.req = '0; ifc.data_in = '0; ifc.hold = 1'b0;
        ifc2.req = '0; ifc2.data_in = '0; ifc2.hold = 1'b0;

        // Reset values
        tick();
        @(negedge clk);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_data", ifc.out_data, 0);
        check("rst_out_id", ifc.out_id, 0);
        check("rst_grant", ifc.grant, 0);
        tick();
        rst = 1'b0;

        // Single requester, word 0xA5 from requester 2
        ifc.req = 4'b0100; set_word(2, 'hA5);
        @(negedge clk);
        check("t1_grant", ifc.grant, 4'b0100);
        tick();
        ifc.req = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t1_valid", ifc.out_valid, (c == 3));
            if (c == 3) begin
                check("t1_data", ifc.out_data, 'hA5);
                check("t1_id", ifc.out_id, 2);
            end
            tick();
        end

        rst = 1'b1; tick(); rst = 1'b0;

        // Full contention, data = index
        for (int i = 0; i < NR; i++) set_word(i, i);
        for (int c = 0; c < 12; c++) begin
            ifc.req = (c < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (c < 8) check("t2_grant", ifc.grant, 1 << (c % 4));
            if (c >= 3 && c < 11) begin
                check("t2_valid", ifc.out_valid, 1);
                check("t2_id", ifc.out_id, (c - 3) % 4);
                check("t2_data", ifc.out_data, (c - 3) % 4);
            end
            tick();
        end

        // Hold for two cycles after a grant to requester 1
        ifc.req = 4'b0010; set_word(1, 'h11); set_word(0, 'h22);
        @(negedge clk);
        check("t3_grant1", ifc.grant, 4'b0010);
        tick();
        ifc.req = 4'b0001; ifc.hold = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("t3_grant_hold", ifc.grant, 0);
            tick();
        end
        ifc.hold = 1'b0;
        @(negedge clk);
        check("t3_grant0", ifc.grant, 4'b0001);
        check("t3_valid3", ifc.out_valid, 0);
        tick();
        ifc.req = '0;
        @(negedge clk);
        check("t3_valid4", ifc.out_valid, 0);
        tick();
        @(negedge clk);
        check("t3_valid5", ifc.out_valid, 1);
        check("t3_data5", ifc.out_data, 'h11);
        check("t3_id5", ifc.out_id, 1);
        tick();
        @(negedge clk);
        check("t3_valid6", ifc.out_valid, 1);
        check("t3_data6", ifc.out_data, 'h22);
        check("t3_id6", ifc.out_id, 0);
        tick();

        // Wrap with three requesters
        for (int i = 0; i < 3; i++) set_word2(i, 'h30 + i);
        for (int c = 0; c < 6; c++) begin
            ifc2.req = (c < 4) ? 3'b101 : 3'b000;
            @(negedge clk);
            if (c < 4) check("t4_grant", ifc2.grant, (c % 2) ? 3'b100 : 3'b001);
            if (c >= 2) begin
                check("t4_valid", ifc2.out_valid, 1);
                check("t4_id", ifc2.out_id, (c % 2) ? 2 : 0);
                check("t4_data", ifc2.out_data, (c % 2) ? 'h32 : 'h30);
            end
            tick();
        end

        // Reset mid-flight: grants 1,2,1 leave the pointer at 2
        ifc.req = 4'b0110;
        for (int i = 0; i < NR; i++) set_word(i, 'h40 + i);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_pre_grant", ifc.grant, (c == 1) ? 4'b0100 : 4'b0010);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        check("t5_grant_in_rst", ifc.grant, 0);
        tick();
        rst = 1'b0; ifc.req = '0;
        for (int c = 0; c < DEP + 2; c++) begin
            @(negedge clk);
            check("t5_valid_after_rst", ifc.out_valid, 0);
            tick();
        end
        ifc.req = 4'hF;
        @(negedge clk);
        check("t5_grant_after_rst", ifc.grant, 4'b0001);
        tick();
        ifc.req = '0;

`ifdef DELAY_LINE_ARB_OCC_EN
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ifc.req = (c < 6) ? 4'b0001 : 4'b0000;
            set_word(0, $urandom);
            @(negedge clk);
            check("t6_occupancy", occ, (c <= 5) ? ((c < 3) ? c : 3) : (3 - (c - 6)));
            tick();
        end
`endif

        // Randomized traffic obeying the requester handshake
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = ifc.grant;
            tick();
            rst      = ($urandom_range(0, 199) == 0);
            ifc.hold = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NR; i++) begin
                if (g[i] || !ifc.req[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        ifc.req[i] = 1'b1;
                        set_word(i, $urandom);
                    end else begin
                        ifc.req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    ifc.req[i] = 1'b0;
                end
            end
        end
        rst = 1'b0; ifc.hold = 1'b0; ifc.req = '0;
        for (int c = 0; c < 10; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/delay_line_arbiter.md
# delay_line_arbiter

Shares one DEPTH-stage delay pipeline among NUM_REQ requesters. Each cycle, round-robin arbitration picks at most one request. The granted word enters the pipeline together with the requester's id and emerges exactly DEPTH ticks later. The pipeline is a chain of 1-tick delay registers plus a valid bit and an id field per stage. The block sequences that chain and shares it between requesters, for example the CPU-side delayed signal paths.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each requester's data word
- NUM_REQ, 4, number of requesters; legal range 2..16
- DEPTH, 3, pipeline length in ticks; legal range 1..32
- ID_WIDTH, $clog2(NUM_REQ), width of the requester id (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester request
- data_in  in  NUM_REQ*DATA_WIDTH  requester i's word is in bits [i*DATA_WIDTH +: DATA_WIDTH]
- hold  in  1  stall: freezes the pipeline and blocks all grants
- grant  out  NUM_REQ  one-hot or zero, combinational; the word is accepted at the next rising edge
- out_valid  out  1  the pipeline tail holds a valid entry
- out_data  out  DATA_WIDTH  data at the pipeline tail
- out_id  out  ID_WIDTH  index of the requester that issued the tail entry

## Operation
- Arbitration state: pointer ptr, ID_WIDTH bits, reset to 0.
  - The requester with the highest priority is ptr, then ptr+1, and so on, wrapping modulo NUM_REQ.
  - grant[i]=1 iff req[i]=1, rst=0, hold=0, and no higher-priority requester has req=1.
- On a rising edge with a grant to requester k:
  - Stage 0 loads {valid=1, id=k, data_in[k]}.
  - ptr becomes (k+1) mod NUM_REQ; the wrap goes from NUM_REQ-1 to 0 even when NUM_REQ is not a power of two.
- On a rising edge with hold=0 and no grant:
  - Stage 0 loads valid=0; its data and id fields are don't-care.
  - ptr is unchanged.
- When hold=0, every stage s≥1 loads stage s-1 on each edge. When hold=1, all stages and ptr keep their values.
- Requester handshake:
  - A requester keeps req and its data stable until it sees grant.
  - It may drop req in the cycle after the grant.
  - A request dropped before it is granted is lost; no error is raised.
- Outputs come from the last stage (DEPTH-1).
  - When out_valid=0, out_data and out_id are don't-care.
  - A bench compares them only when out_valid=1.
- There is no output backpressure. The consumer must take the entry in any cycle where out_valid=1 and hold=0.
- Reset:
  - rst=1 on a rising edge clears every stage's valid bit and sets ptr to 0.
  - This holds mid-operation: all in-flight entries are discarded and none appear afterwards.
  - rst has priority over hold.
  - grant is forced to 0 while rst=1.

## Timing
- Reset values after a rst edge: out_valid=0, out_data=0, out_id=0, every stage's valid=0, ptr=0. grant is 0 while rst=1.
- Latency: a grant in cycle t makes out_valid=1 with that word in cycle t+DEPTH, i.e. after DEPTH rising edges, counting only edges where hold=0.
- Throughput: one grant per cycle. A requester holding req continuously under contention is granted at least once every NUM_REQ cycles.
- hold asserted for H cycles delays every in-flight entry and every pending grant by exactly H cycles.
- Simultaneous requests: exactly one grant per cycle; the others stay pending with no loss of state.
- DEPTH=1: stage 0 is also the tail.

## Configuration
- DELAY_LINE_ARB_OCC_EN defined:
  - Adds output port occupancy, width $clog2(DEPTH+1), reset value 0.
  - occupancy equals the number of stages whose valid=1, as a registered count.
  - Update rule:
    - When hold=0, it increments by 1 on a grant and decrements by 1 when the tail is valid.
    - Both in the same cycle leaves it unchanged.
    - When hold=1 it is unchanged.
    - It never exceeds DEPTH.
- DELAY_LINE_ARB_OCC_EN undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Single requester, DEPTH=3: req[2]=1 with data 0xA5 for one cycle.
  - Required: grant=4'b0100 that cycle.
  - Required: out_valid=1, out_data=0xA5, out_id=2 exactly 3 cycles later, for one cycle.
- Full contention: req=4'b1111 held for 8 cycles, each requester's data = its index.
  - Required: grants in order 0,1,2,3,0,1,2,3.
  - Required: the outputs repeat the same id/data order after a 3-cycle lag.
- Hold: grant requester 1 (data 0x11), then hold=1 for 2 cycles with req[0]=1.
  - Required: no grant during hold.
  - Required: 0x11 appears at cycle t+5 instead of t+3.
  - Required: requester 0 is granted in the first cycle after hold drops.
- Wrap with NUM_REQ=3: req=3'b101, ptr initially 0.
  - Required: grants alternate 0,2,0,2.
  - Required: ptr goes 1,0,1,0 (2 wraps to 0).
- Reset mid-flight: issue 3 grants, then assert rst for 1 cycle.
  - Required: out_valid stays 0 for the next DEPTH+2 cycles.
  - Required: the next grant after rst goes to requester 0 when all requesters request.
- With DELAY_LINE_ARB_OCC_EN defined: continuous single-requester grants with DEPTH=3.
  - Required: occupancy goes 0,1,2,3 and then holds at 3.
  - Required: after req drops, it goes 2,1,0.
